// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared types, error codes and width helper for the frequency meter
// Contents: state_t (FSM encoding), ERR_* result codes, calc_num_w() numerator width.
package freq_meter_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_PRE, ST_GATE, ST_POST, ST_DIV, ST_DONE} state_t;
    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_NOSIG = 2'd1;
    localparam logic [1:0] ERR_OVF   = 2'd2;
    localparam logic [1:0] ERR_DIV0  = 2'd3;
    function automatic int calc_num_w(input int cnt_w, input int stand_hz);
        return cnt_w + $clog2(stand_hz + 1);
    endfunction
endpackage

// File: rtl/freq_meter_seq_divider.sv
// seq_divider: restoring radix-2 divider, one quotient bit per sys_clk cycle
// Ports: sys_clk, sys_rst_n (async, active-low); start loads num/den; busy high for NUM_W
//        cycles; done pulses one cycle with quo valid (quo holds until the next start).
module seq_divider
    import freq_meter_pkg::*;
#(
    parameter int NUM_W = 59,
    parameter int DEN_W = 32
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] quo
);
    localparam int CW = $clog2(NUM_W + 1);
    logic [DEN_W-1:0] rem, diff;
    logic [DEN_W:0]   rem_sh;
    logic [CW-1:0]    cnt;
    logic             ge;
    // quo doubles as the dividend shift register: numerator bits leave the top
    // while quotient bits enter at the bottom
    always_comb begin
        rem_sh = {rem, quo[NUM_W-1]};
        ge     = rem_sh >= {1'b0, den};
        diff   = rem_sh[DEN_W-1:0] - den;
    end
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rem  <= '0;
            quo  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else if (start) begin
            rem  <= '0;
            quo  <= num;
            cnt  <= CW'(NUM_W);
            busy <= 1'b1;
            done <= 1'b0;
        end else begin
            done <= busy && cnt == CW'(1);
            if (busy) begin
                rem  <= ge ? diff : rem_sh[DEN_W-1:0];
                quo  <= {quo[NUM_W-2:0], ge};
                cnt  <= cnt - CW'(1);
                busy <= cnt != CW'(1);
            end
        end
    end
endmodule

// File: rtl/freq_meter_seq.sv
// freq_meter_seq: equal-precision frequency meter, f = X*STAND_HZ/Y via sequential divide
// Ports: sys_clk/sys_rst_n (async active-low, resets all domains); clk_test measured clock;
//        clk_stand reference at STAND_HZ; start pulse / cont_en level request measurements;
//        busy, done (1-cycle), err (0 ok,1 no signal,2 overflow,3 div0), freq (last good Hz).
// Build option: define FREQ_METER_ROUND_EN for round-to-nearest quotient (one extra divide cycle).
module freq_meter_seq
    import freq_meter_pkg::*;
#(
    parameter int STAND_HZ  = 100_000_000,
    parameter int GATE_CYC  = 50_000_000,
    parameter int GUARD_CYC = 12_500_000,
    parameter int CNT_W     = 32,
    parameter int FREQ_W    = 34
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              clk_test,
    input  logic              clk_stand,
    input  logic              start,
    input  logic              cont_en,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err,
    output logic [FREQ_W-1:0] freq
);
    localparam int NUM_W = calc_num_w(CNT_W, STAND_HZ);
`ifdef FREQ_METER_ROUND_EN
    localparam int DIV_W = NUM_W + 1;
`else
    localparam int DIV_W = NUM_W;
`endif
    localparam logic [DIV_W-1:0] STAND_K  = DIV_W'(STAND_HZ);
    localparam logic [31:0]      GUARD_M1 = 32'(GUARD_CYC - 1);
    localparam logic [31:0]      GATE_M1  = 32'(GATE_CYC - 1);

    state_t             state, state_nx;
    logic [31:0]        tmr, tmr_nx;
    logic               gate_s, busy_r, seen_x, seen_y, div_start, div_busy, div_done;
    logic [2:0]         tx, ty;
    logic [1:0]         err_code;
    logic [DIV_W-1:0]   num, div_quo;
    logic [1:0]         gx, gy;
    logic               gate_a, ovf_x, ovf_y, cap_ovf_x, cap_ovf_y, tog_x, tog_y;
    logic [CNT_W-1:0]   cnt_x, cnt_y, cap_x, cap_y;

    // clk_test domain: gate sync, X counter, capture on gate fall
    always_ff @(posedge clk_test or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            gx        <= '0;
            gate_a    <= 1'b0;
            cnt_x     <= '0;
            ovf_x     <= 1'b0;
            cap_x     <= '0;
            cap_ovf_x <= 1'b0;
            tog_x     <= 1'b0;
        end else begin
            gx     <= {gx[0], gate_s};
            gate_a <= gx[1];
            cnt_x  <= gate_a ? (&cnt_x ? cnt_x : cnt_x + CNT_W'(1)) : '0;
            ovf_x  <= gate_a & (ovf_x | &cnt_x);
            // this edge is the last one inside the gate, hence count+1
            if (gate_a && !gx[1]) begin
                cap_x     <= &cnt_x ? cnt_x : cnt_x + CNT_W'(1);
                cap_ovf_x <= ovf_x | &cnt_x;
                tog_x     <= ~tog_x;
            end
        end
    end

    // clk_stand domain: gate_a sync, Y counter, capture on gate fall
    always_ff @(posedge clk_stand or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            gy        <= '0;
            cnt_y     <= '0;
            ovf_y     <= 1'b0;
            cap_y     <= '0;
            cap_ovf_y <= 1'b0;
            tog_y     <= 1'b0;
        end else begin
            gy    <= {gy[0], gate_a};
            cnt_y <= gy[1] ? (&cnt_y ? cnt_y : cnt_y + CNT_W'(1)) : '0;
            ovf_y <= gy[1] & (ovf_y | &cnt_y);
            if (gy[1] && !gy[0]) begin
                cap_y     <= &cnt_y ? cnt_y : cnt_y + CNT_W'(1);
                cap_ovf_y <= ovf_y | &cnt_y;
                tog_y     <= ~tog_y;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= ST_IDLE;
            tmr   <= '0;
        end else begin
            state <= state_nx;
            tmr   <= tmr_nx;
        end
    end

    // capture registers are stable once both toggles have been seen, so reading
    // them here in POST is safe
    always_comb begin
        state_nx  = state;
        tmr_nx    = tmr - 32'd1;
        div_start = 1'b0;
        err_code  = ERR_OK;
        case (state)
            ST_IDLE: begin
                state_nx = (start || cont_en) ? ST_PRE : ST_IDLE;
                tmr_nx   = GUARD_M1;
            end
            ST_PRE: if (tmr == '0) begin
                state_nx = ST_GATE;
                tmr_nx   = GATE_M1;
            end
            ST_GATE: if (tmr == '0) begin
                state_nx = ST_POST;
                tmr_nx   = GUARD_M1;
            end
            ST_POST: if (tmr == '0) begin
                err_code  = !(seen_x && seen_y) ? ERR_NOSIG :
                            (cap_ovf_x || cap_ovf_y) ? ERR_OVF :
                            (cap_y == '0) ? ERR_DIV0 : ERR_OK;
                div_start = err_code == ERR_OK;
                state_nx  = div_start ? ST_DIV : ST_DONE;
            end
            ST_DIV: state_nx = div_done ? ST_DONE : ST_DIV;
            ST_DONE: begin
                state_nx = cont_en ? ST_PRE : ST_IDLE;
                tmr_nx   = GUARD_M1;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            busy_r <= 1'b0;
            done   <= 1'b0;
            gate_s <= 1'b0;
            err    <= ERR_OK;
            freq   <= '0;
            tx     <= '0;
            ty     <= '0;
            seen_x <= 1'b0;
            seen_y <= 1'b0;
        end else begin
            busy_r <= state_nx != ST_IDLE;
            done   <= state_nx == ST_DONE;
            gate_s <= state_nx == ST_GATE;
            tx     <= {tx[1:0], tog_x};
            ty     <= {ty[1:0], tog_y};
            seen_x <= (state == ST_IDLE || state == ST_DONE) ? 1'b0 : seen_x | (tx[2] ^ tx[1]);
            seen_y <= (state == ST_IDLE || state == ST_DONE) ? 1'b0 : seen_y | (ty[2] ^ ty[1]);
            if (state_nx == ST_DONE) begin
                err <= err_code;
                if (err_code == ERR_OK)
                    freq <= |(div_quo >> FREQ_W) ? '1 : FREQ_W'(div_quo);
            end
        end
    end

`ifdef FREQ_METER_ROUND_EN
    assign num = DIV_W'(cap_x) * STAND_K + DIV_W'(cap_y >> 1);
`else
    assign num = DIV_W'(cap_x) * STAND_K;
`endif
    assign busy = busy_r | div_busy;

    seq_divider #(.NUM_W(DIV_W), .DEN_W(CNT_W)) u_div (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (div_start),
        .num       (num),
        .den       (cap_y),
        .busy      (div_busy),
        .done      (div_done),
        .quo       (div_quo)
    );
endmodule
